// File: rtl/exec_controller_if.sv
// Command/status bundle between the debug UART front end, the datapath and exec_controller.
// Master drives commands and datapath status; slave is the controller itself.
interface exec_controller_if #(
  parameter int UART_BITS  = 8,
  parameter int CYCLE_BITS = 32
);
  logic                  rx_done;
  logic [UART_BITS-1:0]  rx_data;
  logic                  loaded;
  logic                  halt;
  logic                  dump_done;
  logic                  enable;
  logic                  dump_req;
  logic [CYCLE_BITS-1:0] cycle_count;
  logic [2:0]            state;
  logic                  halted;

  modport master (
    output rx_done, rx_data, loaded, halt, dump_done,
    input  enable, dump_req, cycle_count, state, halted
  );

  modport slave (
    input  rx_done, rx_data, loaded, halt, dump_done,
    output enable, dump_req, cycle_count, state, halted
  );
endinterface

// File: rtl/exec_controller.sv
// Debug execution sequencer: decodes UART commands into run/step/stop/clear, gates the
// datapath enable, counts executed cycles and requests a state dump after each stop.
module exec_controller #(
  parameter int                   UART_BITS  = 8,
  parameter int                   CYCLE_BITS = 32,
  parameter logic [UART_BITS-1:0] CMD_RUN    = 8'h52,
  parameter logic [UART_BITS-1:0] CMD_STEP   = 8'h53,
  parameter logic [UART_BITS-1:0] CMD_STOP   = 8'h50,
  parameter logic [UART_BITS-1:0] CMD_CLEAR  = 8'h43
) (
  input  logic               clk,
  input  logic               rst_n,
  exec_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic                  enable_reg, enable_next;
  logic                  dump_req_reg, dump_req_next;
  logic                  halted_reg, halted_next;
  logic [CYCLE_BITS-1:0] count_reg, count_next;

  logic cmd_run, cmd_step, cmd_stop, cmd_clear;
  logic halt_seen;
  logic clear_ok;

  assign cmd_run   = bus.rx_done && (bus.rx_data == CMD_RUN);
  assign cmd_step  = bus.rx_done && (bus.rx_data == CMD_STEP);
  assign cmd_stop  = bus.rx_done && (bus.rx_data == CMD_STOP);
  assign cmd_clear = bus.rx_done && (bus.rx_data == CMD_CLEAR);

  // Halt is only meaningful while the datapath is actually advancing.
  assign halt_seen = enable_reg && bus.halt;
  assign clear_ok  = cmd_clear && ((state_reg == ST_IDLE) || (state_reg == ST_HALTED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      enable_reg   <= 1'b0;
      dump_req_reg <= 1'b0;
      halted_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      enable_reg   <= enable_next;
      dump_req_reg <= dump_req_next;
      halted_reg   <= halted_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_run && bus.loaded)       state_next = ST_RUN;
        else if (cmd_step && bus.loaded) state_next = ST_STEP;
        else                             state_next = ST_IDLE;
      end
      ST_RUN:    state_next = (halt_seen || cmd_stop) ? ST_DUMP : ST_RUN;
      ST_STEP:   state_next = ST_DUMP;
      ST_DUMP: begin
        if (bus.dump_done) state_next = halted_reg ? ST_HALTED : ST_IDLE;
        else               state_next = ST_DUMP;
      end
      ST_HALTED: state_next = cmd_clear ? ST_IDLE : ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it cycle for cycle.
  always_comb begin
    enable_next   = (state_next == ST_RUN) || (state_next == ST_STEP);
    dump_req_next = (state_next == ST_DUMP);
    halted_next   = halted_reg;
    count_next    = count_reg;
    if (halt_seen)
      halted_next = 1'b1;
    if (enable_reg && !(&count_reg))
      count_next = count_reg + 1'b1;
    if (clear_ok) begin
      halted_next = 1'b0;
      count_next  = '0;
    end
  end

  assign bus.enable      = enable_reg;
  assign bus.dump_req    = dump_req_reg;
  assign bus.halted      = halted_reg;
  assign bus.cycle_count = count_reg;
  assign bus.state       = state_reg;

endmodule

// File: tb/tb_exec_controller.sv
// Randomised scoreboard bench for exec_controller: each command sequence pushes the dump
// it should produce; a monitor pops and compares whenever a dump request appears.
module tb_exec_controller;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DUMP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_controller_if #(.UART_BITS(8), .CYCLE_BITS(32)) bus ();
  exec_controller_if #(.UART_BITS(8), .CYCLE_BITS(4))  bus4 ();

  exec_controller #(.UART_BITS(8), .CYCLE_BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exec_controller #(.UART_BITS(8), .CYCLE_BITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus4.rx_done   = bus.rx_done;
  assign bus4.rx_data   = bus.rx_data;
  assign bus4.loaded    = bus.loaded;
  assign bus4.halt      = bus.halt;
  assign bus4.dump_done = bus.dump_done;

  typedef struct {
    longint unsigned count;
    bit              halted;
    logic [2:0]      next_state;
  } dump_rec_t;

  dump_rec_t       exp_q[$];
  int              errors = 0;
  int              checks = 0;
  longint unsigned m_count = 0;
  bit              m_halted = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned sat4(input longint unsigned c);
    return (c > 15) ? 15 : c;
  endfunction

  // ---------------- monitor ----------------
  dump_rec_t cur;
  bit        pending = 1'b0;
  logic      dump_req_prev = 1'b0;

  always @(negedge clk) begin
    check("enable_and_dump_req", longint'(bus.enable & bus.dump_req), 0);
    if (bus.dump_req && !dump_req_prev) begin
      check("dump_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        pending = 1'b1;
        $display("dump: count=%0d count4=%0d halted=%0d", bus.cycle_count, bus4.cycle_count, bus.halted);
        check("dump_count", bus.cycle_count, cur.count);
        check("dump_count4", bus4.cycle_count, sat4(cur.count));
        check("dump_halted", bus.halted, cur.halted);
        check("dump_enable_low", bus.enable, 0);
        check("dump_state", bus.state, S_DUMP);
      end
    end else if (!bus.dump_req && dump_req_prev && pending) begin
      check("post_dump_state", bus.state, cur.next_state);
      pending = 1'b0;
    end
    dump_req_prev = bus.dump_req;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic push_dump(input logic [2:0] next_state);
    dump_rec_t r;
    r.count      = m_count;
    r.halted     = m_halted;
    r.next_state = next_state;
    exp_q.push_back(r);
  endtask

  task automatic finish_dump();
    int n = 0;
    while (!bus.dump_req && n < 20) begin
      tick();
      n++;
    end
    check("dump_req_seen", bus.dump_req, 1);
    repeat ($urandom_range(0, 3)) tick();
    if ($urandom_range(0, 1) == 1) send(8'h52);
    bus.dump_done = 1'b1;
    tick();
    bus.dump_done = 1'b0;
    tick();
  endtask

  task automatic handle_halted();
    check("halted_state", bus.state, S_HALTED);
    send(8'h52);
    send(8'h53);
    check("halted_ignores_run_en", bus.enable, 0);
    check("halted_ignores_run_st", bus.state, S_HALTED);
    send(8'h43);
    m_count  = 0;
    m_halted = 1'b0;
    check("clear_state", bus.state, S_IDLE);
    check("clear_count", bus.cycle_count, 0);
    check("clear_count4", bus4.cycle_count, 0);
    check("clear_halted", bus.halted, 0);
    repeat (3) tick();
    check("stale_halt_idle", bus.state, S_IDLE);
    bus.halt = 1'b0;
  endtask

  task automatic do_step(input bit with_halt);
    m_count++;
    if (with_halt) m_halted = 1'b1;
    push_dump(m_halted ? S_HALTED : S_IDLE);
    bus.halt = with_halt;
    send(8'h53);
    @(negedge clk);
    check("step_en_n1", bus.enable, 1);
    check("step_req_n1", bus.dump_req, 0);
    @(negedge clk);
    check("step_en_n2", bus.enable, 0);
    check("step_req_n2", bus.dump_req, 1);
    finish_dump();
    if (m_halted) handle_halted();
  endtask

  // kind: 0 = stop, 1 = halt, 2 = stop and halt in the same cycle
  task automatic do_run(input int k, input int kind);
    logic [7:0] junk;
    m_count += longint'(k);
    if (kind != 0) m_halted = 1'b1;
    push_dump(m_halted ? S_HALTED : S_IDLE);
    send(8'h52);
    for (int j = 1; j < k; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h50) junk = 8'h43;
        send(junk);
      end else begin
        tick();
      end
    end
    if (kind != 0) bus.halt = 1'b1;
    if (kind != 1) send(8'h50);
    else tick();
    finish_dump();
    if (m_halted) handle_halted();
  endtask

  task automatic do_junk();
    logic [7:0] junk;
    junk = 8'($urandom);
    if (junk == 8'h52 || junk == 8'h53 || junk == 8'h43) junk = 8'h50;
    send(junk);
    bus.dump_done = 1'b1;
    tick();
    bus.dump_done = 1'b0;
    tick();
    check("junk_state", bus.state, S_IDLE);
    check("junk_enable", bus.enable, 0);
    check("junk_dump_req", bus.dump_req, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.loaded    = 1'b0;
    bus.halt      = 1'b0;
    bus.dump_done = 1'b0;
    #12;
    check("rst_enable", bus.enable, 0);
    check("rst_dump_req", bus.dump_req, 0);
    check("rst_count", bus.cycle_count, 0);
    check("rst_state", bus.state, S_IDLE);
    check("rst_halted", bus.halted, 0);
    rst_n = 1'b1;
    tick();

    // Commands must be ignored with no program loaded.
    send(8'h52);
    send(8'h53);
    tick();
    check("unloaded_enable", bus.enable, 0);
    check("unloaded_state", bus.state, S_IDLE);
    check("unloaded_count", bus.cycle_count, 0);
    bus.loaded = 1'b1;

    do_step(1'b0);
    do_run(20, 0);
    do_run(10, 1);
    do_run(5, 2);

    // Asynchronous reset while a dump is pending.
    m_count++;
    push_dump(S_IDLE);
    send(8'h53);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_req", bus.dump_req, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_enable", bus.enable, 0);
    check("arst_dump_req", bus.dump_req, 0);
    check("arst_count", bus.cycle_count, 0);
    check("arst_count4", bus4.cycle_count, 0);
    check("arst_state", bus.state, S_IDLE);
    check("arst_halted", bus.halted, 0);
    m_count  = 0;
    m_halted = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_step(1'b0);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 6))
        0:       do_step(1'b0);
        1:       do_step(1'b1);
        2:       do_run(int'($urandom_range(1, 25)), 0);
        3:       do_run(int'($urandom_range(1, 25)), 1);
        4:       do_run(int'($urandom_range(1, 25)), 2);
        5:       do_junk();
        default: begin
          send(8'h43);
          m_count = 0;
          check("idle_clear_count", bus.cycle_count, 0);
        end
      endcase
    end

    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 50) begin
      tick();
      n++;
    end
    check("scoreboard_empty", longint'(exp_q.size()), 0);
    check("scoreboard_idle", longint'(pending), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
